// File: rtl/mycpu_pkg.sv
// mycpu_pkg: shared encodings for the mycpu datapath and its fetch/decode/execute control unit.
package mycpu_pkg;

  typedef enum logic [3:0] {
    FMOVA = 4'h0,
    FINC  = 4'h1,
    FDEC  = 4'h2,
    FADD  = 4'h3,
    FSUB  = 4'h4,
    FCLR  = 4'h5,
    FAND  = 4'h6,
    FOR   = 4'h7,
    FXOR  = 4'h8,
    FNOT  = 4'h9,
    FSHR  = 4'hA,
    FSHL  = 4'hB
  } fs_t;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_HALT
  } ctrl_state_t;

  typedef enum logic [3:0] {
    OP_MOVA = 4'h0,
    OP_INC  = 4'h1,
    OP_DEC  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_CLR  = 4'h5,
    OP_BRZ  = 4'h8,
    OP_BRN  = 4'h9,
    OP_JMP  = 4'hA,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_BRZ,
    CLS_BRN,
    CLS_JMP,
    CLS_HALT,
    CLS_NOP
  } cls_t;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int D_MSB   = 11;
  localparam int D_LSB   = 9;
  localparam int A_MSB   = 8;
  localparam int A_LSB   = 6;
  localparam int B_MSB   = 5;
  localparam int B_LSB   = 3;
  localparam int OFF_MSB = 11;
  localparam int OFF_W   = 12;

  function automatic fs_t op_to_fs(input opcode_t op);
    case (op)
      OP_INC:  return FINC;
      OP_DEC:  return FDEC;
      OP_ADD:  return FADD;
      OP_SUB:  return FSUB;
      OP_CLR:  return FCLR;
      default: return FMOVA;
    endcase
  endfunction

endpackage

// File: rtl/mycpu_decode.sv
// Combinational instruction decoder: IR in, function select, register selects,
// opcode class, sign-extended branch offset and illegal flag out.
module mycpu_decode
  import mycpu_pkg::*;
(
  input  logic [15:0] i_ir,
  output logic [3:0]  o_fs,
  output logic [2:0]  o_a_sel,
  output logic [2:0]  o_b_sel,
  output logic [2:0]  o_d_sel,
  output logic [2:0]  o_cls,
  output logic [15:0] o_off,
  output logic        o_illegal
);

  opcode_t w_op;

  assign w_op    = opcode_t'(i_ir[OP_MSB:OP_LSB]);
  assign o_fs    = op_to_fs(w_op);
  assign o_d_sel = i_ir[D_MSB:D_LSB];
  assign o_a_sel = i_ir[A_MSB:A_LSB];
  assign o_b_sel = i_ir[B_MSB:B_LSB];
  assign o_off   = {{(16-OFF_W){i_ir[OFF_MSB]}}, i_ir[OFF_MSB:0]};

  always_comb begin
    o_cls     = CLS_NOP;
    o_illegal = 1'b0;
    case (w_op)
      OP_MOVA, OP_INC, OP_DEC,
      OP_ADD, OP_SUB, OP_CLR: o_cls = CLS_ALU;
      OP_BRZ:                 o_cls = CLS_BRZ;
      OP_BRN:                 o_cls = CLS_BRN;
      OP_JMP:                 o_cls = CLS_JMP;
      OP_HALT:                o_cls = CLS_HALT;
      default:                o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mycpu_ctrl.sv
// mycpu_ctrl: multi-cycle fetch/decode/execute sequencer for the 16-bit mycpu datapath.
// Define CU_ILLEGAL_TRAP_EN to halt on an illegal opcode instead of treating it as a NOP.
module mycpu_ctrl
  import mycpu_pkg::*;
#(
  parameter int          PC_W     = 16,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic [3:0]      fs_out,
  output logic [2:0]      a_sel,
  output logic [2:0]      b_sel,
  output logic [2:0]      d_sel,
  output logic            reg_we,
  input  logic            z_in,
  input  logic            n_in,
  output logic            z_flag,
  output logic            n_flag,
  output logic            halted,
  output logic            err
);

  ctrl_state_t     r_state;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic            r_req;
  logic            r_we;
  logic            r_z;
  logic            r_n;
  logic            r_halt;
  logic            r_err;

  logic [3:0]      w_fs;
  logic [2:0]      w_cls;
  logic [15:0]     w_off16;
  logic            w_illegal;
  logic [PC_W-1:0] w_off;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_br;

  mycpu_decode u_dec (
    .i_ir      (r_ir),
    .o_fs      (w_fs),
    .o_a_sel   (a_sel),
    .o_b_sel   (b_sel),
    .o_d_sel   (d_sel),
    .o_cls     (w_cls),
    .o_off     (w_off16),
    .o_illegal (w_illegal)
  );

  // Branch targets are relative to the already-incremented PC and wrap at PC_W bits.
  assign w_off    = w_off16[PC_W-1:0];
  assign w_pc_inc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign w_pc_br  = r_pc + w_off;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC[PC_W-1:0];
      r_ir    <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_halt  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          // imem_req rises one cycle after reset; acks seen while it is low are ignored.
          if (!r_req) begin
            r_req <= 1'b1;
          end else if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_pc    <= w_pc_inc;
            r_req   <= 1'b0;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_we    <= (cls_t'(w_cls) == CLS_ALU);
          r_state <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          r_state <= ST_FETCH;
          r_req   <= 1'b1;
          case (cls_t'(w_cls))
            CLS_ALU: begin
              r_z <= z_in;
              r_n <= n_in;
            end
            CLS_BRZ: if (r_z) r_pc <= w_pc_br;
            CLS_BRN: if (r_n) r_pc <= w_pc_br;
            CLS_JMP: r_pc <= w_pc_br;
            CLS_HALT: begin
              r_state <= ST_HALT;
              r_req   <= 1'b0;
              r_halt  <= 1'b1;
            end
            default: ;
          endcase
          if (w_illegal) begin
            r_err <= 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
            r_state <= ST_HALT;
            r_req   <= 1'b0;
            r_halt  <= 1'b1;
`endif
          end
        end
        ST_HALT: r_req <= 1'b0;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign fs_out    = w_fs;
  assign reg_we    = r_we;
  assign z_flag    = r_z;
  assign n_flag    = r_n;
  assign halted    = r_halt;
  assign err       = r_err;

endmodule

// File: tb/tb_mycpu_ctrl.sv
// Directed, table-driven bench for mycpu_ctrl with a wait-state-capable instruction memory.
module tb_mycpu_ctrl;
  import mycpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [3:0]  fs_out;
  logic [2:0]  a_sel, b_sel, d_sel;
  logic        reg_we;
  logic        z_in = 1'b0;
  logic        n_in = 1'b0;
  logic        z_flag, n_flag, halted, err;

  logic [15:0] imem [0:65535];
  int          ack_delay = 0;
  int          wcnt = 0;
  logic        ack_force = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mycpu_ctrl #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .fs_out     (fs_out),
    .a_sel      (a_sel),
    .b_sel      (b_sel),
    .d_sel      (d_sel),
    .reg_we     (reg_we),
    .z_in       (z_in),
    .n_in       (n_in),
    .z_flag     (z_flag),
    .n_flag     (n_flag),
    .halted     (halted),
    .err        (err)
  );

  // Memory acks after ack_delay cycles of a held request.
  assign imem_ack   = (imem_req && (wcnt >= ack_delay)) || ack_force;
  assign imem_rdata = imem[imem_addr];
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end

  typedef struct {
    logic [15:0] addr;
    logic [15:0] ir;
    logic        zi;
    logic        ni;
    logic        we;
    logic [3:0]  fs;
    logic [2:0]  d;
    logic [2:0]  a;
    logic [2:0]  b;
    logic        z;
    logic        n;
    logic [15:0] nxt;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_req(input string nm);
    int k;
    k = 0;
    while (!imem_req && k < 20) begin
      tick();
      k++;
    end
    check({nm, "_req_seen"}, imem_req, 1'b1);
  endtask

  // Reset edge with a stray ack present; values checked in the first cycle after reset.
  task automatic do_reset(input string nm);
    @(negedge clk);
    rst = 1'b1;
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    rst = 1'b0;
    check({nm, "_req"},    imem_req,  1'b0);
    check({nm, "_addr"},   imem_addr, 16'h0000);
    check({nm, "_we"},     reg_we,    1'b0);
    check({nm, "_fs"},     fs_out,    FMOVA);
    check({nm, "_sels"},   {d_sel, a_sel, b_sel}, 9'd0);
    check({nm, "_flags"},  {z_flag, n_flag}, 2'b00);
    check({nm, "_halted"}, halted,    1'b0);
    check({nm, "_err"},    err,       1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{16'h0000, 16'h3A50, 1'b0, 1'b1, 1'b1, FADD,  3'd5, 3'd1, 3'd2, 1'b0, 1'b1, 16'h0001};
    vecs[1]  = '{16'h0001, 16'hA002, 1'b1, 1'b0, 1'b0, FMOVA, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 16'h0004};
    vecs[2]  = '{16'h0004, 16'h4298, 1'b1, 1'b0, 1'b1, FSUB,  3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 16'h0005};
    vecs[3]  = '{16'h0005, 16'h8FFE, 1'b0, 1'b1, 1'b0, FMOVA, 3'd7, 3'd7, 3'd7, 1'b1, 1'b0, 16'h0004};
    vecs[4]  = '{16'h0004, 16'h4298, 1'b0, 1'b1, 1'b1, FSUB,  3'd1, 3'd2, 3'd3, 1'b0, 1'b1, 16'h0005};
    vecs[5]  = '{16'h0005, 16'h8FFE, 1'b1, 1'b0, 1'b0, FMOVA, 3'd7, 3'd7, 3'd7, 1'b0, 1'b1, 16'h0006};
    vecs[6]  = '{16'h0006, 16'h9003, 1'b1, 1'b1, 1'b0, FMOVA, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 16'h000A};
    vecs[7]  = '{16'h000A, 16'h2700, 1'b1, 1'b1, 1'b1, FDEC,  3'd3, 3'd4, 3'd0, 1'b1, 1'b1, 16'h000B};
    vecs[8]  = '{16'h000B, 16'h0DC0, 1'b0, 1'b0, 1'b1, FMOVA, 3'd6, 3'd7, 3'd0, 1'b0, 1'b0, 16'h000C};
    vecs[9]  = '{16'h000C, 16'h9FFF, 1'b1, 1'b1, 1'b0, FMOVA, 3'd7, 3'd7, 3'd7, 1'b0, 1'b0, 16'h000D};
    vecs[10] = '{16'h000D, 16'h5800, 1'b1, 1'b0, 1'b1, FCLR,  3'd4, 3'd0, 3'd0, 1'b1, 1'b0, 16'h000E};
    vecs[11] = '{16'h000E, 16'hAFF0, 1'b0, 1'b1, 1'b0, FMOVA, 3'd7, 3'd7, 3'd6, 1'b1, 1'b0, 16'hFFFF};
    vecs[12] = '{16'hFFFF, 16'hA7FF, 1'b0, 1'b0, 1'b0, FMOVA, 3'd3, 3'd7, 3'd7, 1'b1, 1'b0, 16'h07FF};

    for (int i = 0; i < 65536; i++) imem[i] = 16'h0000;
    for (int i = 0; i < 13; i++) imem[vecs[i].addr] = vecs[i].ir;
    imem[16'h07FF] = 16'h6000;

    // Reset, then an ack while imem_req is low must not start a fetch.
    do_reset("rst0");
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    check("noreq_ack_req",  imem_req,  1'b1);
    check("noreq_ack_addr", imem_addr, 16'h0000);

    for (int i = 0; i < 13; i++) begin
      wait_req($sformatf("v%0d", i));
      check($sformatf("v%0d_fetch_addr", i), imem_addr, vecs[i].addr);
      z_in = vecs[i].zi;
      n_in = vecs[i].ni;
      tick();
      check($sformatf("v%0d_dec_we", i),   reg_we, 1'b0);
      check($sformatf("v%0d_dec_req", i),  imem_req, 1'b0);
      check($sformatf("v%0d_dec_sels", i), {d_sel, a_sel, b_sel}, {vecs[i].d, vecs[i].a, vecs[i].b});
      check($sformatf("v%0d_dec_fs", i),   fs_out, vecs[i].fs);
      tick();
      check($sformatf("v%0d_exe_we", i),   reg_we, vecs[i].we);
      check($sformatf("v%0d_exe_fs", i),   fs_out, vecs[i].fs);
      tick();
      check($sformatf("v%0d_flags", i),    {z_flag, n_flag}, {vecs[i].z, vecs[i].n});
      check($sformatf("v%0d_next", i),     imem_addr, vecs[i].nxt);
      check($sformatf("v%0d_st", i),       {imem_req, halted, err}, 3'b100);
    end

    // Illegal opcode 6 at 0x07FF.
    wait_req("ill");
    check("ill_addr", imem_addr, 16'h07FF);
    z_in = 1'b0;
    n_in = 1'b1;
    tick();
    check("ill_dec_err", err, 1'b0);
    tick();
    check("ill_exe_we", reg_we, 1'b0);
    ack_delay = 100;
    tick();
    check("ill_err",   err, 1'b1);
    check("ill_flags", {z_flag, n_flag}, 2'b10);
`ifdef CU_ILLEGAL_TRAP_EN
    check("ill_halted", halted,   1'b1);
    check("ill_req",    imem_req, 1'b0);
    tick();
    check("ill_req2",   imem_req, 1'b0);
    check("ill_halt2",  halted,   1'b1);
    check("ill_we2",    reg_we,   1'b0);
`else
    check("ill_halted", halted,    1'b0);
    check("ill_req",    imem_req,  1'b1);
    check("ill_next",   imem_addr, 16'h0800);
    tick();
    check("ill_hold_req",  imem_req,  1'b1);
    check("ill_hold_addr", imem_addr, 16'h0800);
    check("ill_we2",       reg_we,    1'b0);
`endif

    // Reset while waiting in FETCH (or sitting in HALT when trapping).
    do_reset("rst1");

    // Four wait cycles: request and address held for five cycles, IR loaded only on the ack.
    ack_delay = 4;
    imem[16'h0001] = 16'hF000;
    z_in = 1'b1;
    n_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("ws%0d_req", i),  imem_req,  1'b1);
      check($sformatf("ws%0d_addr", i), imem_addr, 16'h0000);
      check($sformatf("ws%0d_d", i),    d_sel,     3'd0);
      check($sformatf("ws%0d_we", i),   reg_we,    1'b0);
    end
    tick();
    check("ws_dec_req",  imem_req, 1'b0);
    check("ws_dec_sels", {d_sel, a_sel, b_sel}, {3'd5, 3'd1, 3'd2});
    tick();
    check("ws_exe_we", reg_we, 1'b1);
    check("ws_exe_fs", fs_out, FADD);
    ack_delay = 0;

    // HALT opcode, then reset out of HALT.
    tick();
    check("h_flags", {z_flag, n_flag}, 2'b11);
    check("h_addr",  imem_addr, 16'h0001);
    tick();
    tick();
    check("h_exe_we", reg_we, 1'b0);
    tick();
    check("h_halted", halted,   1'b1);
    check("h_req",    imem_req, 1'b0);
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    check("h_stay",   {halted, imem_req, reg_we}, 3'b100);
    check("h_pc",     imem_addr, 16'h0002);
    do_reset("rst2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
